// File: rtl/button_debouncer_pkg.sv
// Shared types and constants for the button_debouncer block.
package button_debouncer_pkg;

  // Default acceptance window: 1 ms at 50 MHz.
  localparam int unsigned DEFAULT_STABLE_CYCLES = 32'd50000;

  typedef enum logic [1:0] {
    REL_STABLE = 2'd0,
    PRESS_CNT  = 2'd1,
    PRS_STABLE = 2'd2,
    REL_CNT    = 2'd3
  } db_state_e;

  // Pin level seen while the button is not pressed.
  function automatic logic released_level(input bit active_low);
    if (active_low) begin
      return 1'b1;
    end else begin
      return 1'b0;
    end
  endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Button bus between board pins and ButtonShaper consumers.
// bounce_cnt exists only when BUTTON_DEBOUNCE_BOUNCE_CNT_EN is defined.
interface button_debouncer_if #(
  parameter int NUM_BTNS = 3
);
  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] btn_clean;
  logic [NUM_BTNS-1:0] btn_changed;
`ifdef BUTTON_DEBOUNCE_BOUNCE_CNT_EN
  logic [NUM_BTNS*8-1:0] bounce_cnt;
`endif

  modport master (
    output btn_raw,
    input  btn_clean,
    input  btn_changed
`ifdef BUTTON_DEBOUNCE_BOUNCE_CNT_EN
    ,
    input  bounce_cnt
`endif
  );

  modport slave (
    input  btn_raw,
    output btn_clean,
    output btn_changed
`ifdef BUTTON_DEBOUNCE_BOUNCE_CNT_EN
    ,
    output bounce_cnt
`endif
  );
endinterface

// File: rtl/button_debouncer_channel.sv
// One debounce channel: 2-FF synchronizer, 4-state FSM and stable-sample counter.
// BUTTON_DEBOUNCE_BOUNCE_CNT_EN adds a saturating count of rejected transitions.
module button_debouncer_channel
  import button_debouncer_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_clean,
  output logic btn_changed
`ifdef BUTTON_DEBOUNCE_BOUNCE_CNT_EN
  ,
  output logic [7:0] bounce_cnt
`endif
);
  localparam int unsigned      CNT_W         = $clog2(STABLE_CYCLES + 32'd1);
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(STABLE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(32'd1);
  localparam bit               SINGLE_SAMPLE = (STABLE_CYCLES == 32'd1);
  localparam logic             REL_LEVEL     = released_level(ACTIVE_LOW);

  logic             sync1_r, sync2_r;
  logic             sample_s;
  db_state_e        state_r, state_next_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  logic             clean_r, clean_next_s;
  logic             changed_r, changed_next_s;

  // 1 = pressed, independent of pin polarity.
  assign sample_s = sync2_r ^ ACTIVE_LOW;

  // Synchronizer, FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r   <= REL_LEVEL;
      sync2_r   <= REL_LEVEL;
      state_r   <= REL_STABLE;
      cnt_r     <= '0;
      clean_r   <= 1'b0;
      changed_r <= 1'b0;
    end else begin
      sync1_r   <= btn_raw;
      sync2_r   <= sync1_r;
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      clean_r   <= clean_next_s;
      changed_r <= changed_next_s;
    end
  end

  // Next-state, counter and output decode.
  always_comb begin
    state_next_s   = state_r;
    cnt_next_s     = '0;
    clean_next_s   = clean_r;
    changed_next_s = 1'b0;
    case (state_r)
      REL_STABLE: begin
        if (sample_s && SINGLE_SAMPLE) begin
          state_next_s   = PRS_STABLE;
          clean_next_s   = 1'b1;
          changed_next_s = 1'b1;
        end else if (sample_s) begin
          state_next_s = PRESS_CNT;
          cnt_next_s   = CNT_ONE;
        end else begin
          state_next_s = REL_STABLE;
        end
      end
      PRESS_CNT: begin
        if (!sample_s) begin
          state_next_s = REL_STABLE;
        end else if (cnt_r == CNT_LAST) begin
          state_next_s   = PRS_STABLE;
          clean_next_s   = 1'b1;
          changed_next_s = 1'b1;
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      PRS_STABLE: begin
        if (!sample_s && SINGLE_SAMPLE) begin
          state_next_s   = REL_STABLE;
          clean_next_s   = 1'b0;
          changed_next_s = 1'b1;
        end else if (!sample_s) begin
          state_next_s = REL_CNT;
          cnt_next_s   = CNT_ONE;
        end else begin
          state_next_s = PRS_STABLE;
        end
      end
      REL_CNT: begin
        if (sample_s) begin
          state_next_s = PRS_STABLE;
        end else if (cnt_r == CNT_LAST) begin
          state_next_s   = REL_STABLE;
          clean_next_s   = 1'b0;
          changed_next_s = 1'b1;
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_next_s = REL_STABLE;
        clean_next_s = 1'b0;
      end
    endcase
  end

  assign btn_clean   = clean_r;
  assign btn_changed = changed_r;

`ifdef BUTTON_DEBOUNCE_BOUNCE_CNT_EN
  logic       rejected_s;
  logic [7:0] bounce_r;

  assign rejected_s = ((state_r == PRESS_CNT) && !sample_s) ||
                      ((state_r == REL_CNT)   &&  sample_s);

  // Saturating count of transitions abandoned before acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      bounce_r <= 8'd0;
    end else if (rejected_s && (bounce_r != 8'hFF)) begin
      bounce_r <= bounce_r + 8'd1;
    end else begin
      bounce_r <= bounce_r;
    end
  end

  assign bounce_cnt = bounce_r;
`endif

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer feeding ButtonShaper; one channel per button.
// Optional diagnostics: BUTTON_DEBOUNCE_BOUNCE_CNT_EN adds bus.bounce_cnt.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int          NUM_BTNS      = 3,
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input logic              clk,
  input logic              rst,
  button_debouncer_if.slave bus
);

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    button_debouncer_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .ACTIVE_LOW    (ACTIVE_LOW)
    ) u_debounce_channel (
      .clk         (clk),
      .rst         (rst),
      .btn_raw     (bus.btn_raw[i]),
      .btn_clean   (bus.btn_clean[i]),
      .btn_changed (bus.btn_changed[i])
`ifdef BUTTON_DEBOUNCE_BOUNCE_CNT_EN
      ,
      .bounce_cnt  (bus.bounce_cnt[i*8 +: 8])
`endif
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench: dut_a uses STABLE_CYCLES=4, dut_b uses STABLE_CYCLES=1, both active-low.
module tb_button_debouncer;
  localparam int NB = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  button_debouncer_if #(.NUM_BTNS(NB)) bus_a ();
  button_debouncer_if #(.NUM_BTNS(NB)) bus_b ();

  button_debouncer #(.NUM_BTNS(NB), .STABLE_CYCLES(4), .ACTIVE_LOW(1'b1)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a)
  );
  button_debouncer #(.NUM_BTNS(NB), .STABLE_CYCLES(1), .ACTIVE_LOW(1'b1)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  typedef struct {
    logic          rst;
    logic [NB-1:0] raw_a, clean_a, chg_a;
    logic [NB-1:0] raw_b, clean_b, chg_b;
  } vec_t;

  typedef struct {
    int            idx;
    logic [NB-1:0] clean_a, chg_a, clean_b, chg_b;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   vidx   = 0;

  // Table helper for dut_a stimulus; dut_b held released.
  task automatic add(input logic r, input logic [NB-1:0] ra, input logic [NB-1:0] ca,
                     input logic [NB-1:0] ga, input int n);
    vec_t v;
    v.rst = r; v.raw_a = ra; v.clean_a = ca; v.chg_a = ga;
    v.raw_b = 3'b111; v.clean_b = 3'b000; v.chg_b = 3'b000;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst           = v.rst;
    bus_a.btn_raw = v.raw_a;
    bus_b.btn_raw = v.raw_b;
    e.idx = vidx; e.clean_a = v.clean_a; e.chg_a = v.chg_a;
    e.clean_b = v.clean_b; e.chg_b = v.chg_b;
    sb.push_back(e);
    vidx++;
    @(posedge clk);
    #1;
    got = sb.pop_front();
    checks++;
    if ({bus_a.btn_clean, bus_a.btn_changed} !== {got.clean_a, got.chg_a}) begin
      errors++;
      $display("FAIL vec%0d dut_a clean/changed: got %b/%b expected %b/%b", got.idx,
               bus_a.btn_clean, bus_a.btn_changed, got.clean_a, got.chg_a);
    end
    checks++;
    if ({bus_b.btn_clean, bus_b.btn_changed} !== {got.clean_b, got.chg_b}) begin
      errors++;
      $display("FAIL vec%0d dut_b clean/changed: got %b/%b expected %b/%b", got.idx,
               bus_b.btn_clean, bus_b.btn_changed, got.clean_b, got.chg_b);
    end
  endtask

  task automatic step(input logic r, input logic [NB-1:0] ra, input logic [NB-1:0] ca,
                      input logic [NB-1:0] ga, input logic [NB-1:0] rb,
                      input logic [NB-1:0] cb, input logic [NB-1:0] gb, input int n);
    vec_t v;
    v.rst = r; v.raw_a = ra; v.clean_a = ca; v.chg_a = ga;
    v.raw_b = rb; v.clean_b = cb; v.chg_b = gb;
    for (int i = 0; i < n; i++) apply(v);
  endtask

`ifdef BUTTON_DEBOUNCE_BOUNCE_CNT_EN
  task automatic check_bounce(input logic [NB*8-1:0] exp_cnt, input string name);
    checks++;
    if (bus_a.bounce_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL %s bounce_cnt: got %h expected %h", name, bus_a.bounce_cnt, exp_cnt);
    end
  endtask
`endif

  initial begin
    bus_a.btn_raw = 3'b111;
    bus_b.btn_raw = 3'b111;

    // Reset with pins released, then idle: no spurious pulses.
    add(1'b1, 3'b111, 3'b000, 3'b000, 3);
    add(1'b0, 3'b111, 3'b000, 3'b000, 3);
    // Channel 0 press and release, 5-cycle latency after first sample.
    add(1'b0, 3'b110, 3'b000, 3'b000, 5);
    add(1'b0, 3'b110, 3'b001, 3'b001, 1);
    add(1'b0, 3'b110, 3'b001, 3'b000, 2);
    add(1'b0, 3'b111, 3'b001, 3'b000, 5);
    add(1'b0, 3'b111, 3'b000, 3'b001, 1);
    add(1'b0, 3'b111, 3'b000, 3'b000, 2);
    // Channel 1 bounces (two rejected press runs), then settles pressed.
    add(1'b0, 3'b101, 3'b000, 3'b000, 2);
    add(1'b0, 3'b111, 3'b000, 3'b000, 2);
    add(1'b0, 3'b101, 3'b000, 3'b000, 2);
    add(1'b0, 3'b111, 3'b000, 3'b000, 2);
    add(1'b0, 3'b101, 3'b000, 3'b000, 5);
    add(1'b0, 3'b101, 3'b010, 3'b010, 1);
    add(1'b0, 3'b101, 3'b010, 3'b000, 2);
    add(1'b0, 3'b111, 3'b010, 3'b000, 5);
    add(1'b0, 3'b111, 3'b000, 3'b010, 1);
    add(1'b0, 3'b111, 3'b000, 3'b000, 2);
    // Channel 2: 3-sample pulse rejected, 4-sample pulse accepted.
    add(1'b0, 3'b011, 3'b000, 3'b000, 3);
    add(1'b0, 3'b111, 3'b000, 3'b000, 6);
    add(1'b0, 3'b011, 3'b000, 3'b000, 4);
    add(1'b0, 3'b111, 3'b000, 3'b000, 1);
    add(1'b0, 3'b111, 3'b100, 3'b100, 1);
    add(1'b0, 3'b111, 3'b100, 3'b000, 3);
    add(1'b0, 3'b111, 3'b000, 3'b100, 1);
    add(1'b0, 3'b111, 3'b000, 3'b000, 2);
    // All channels together.
    add(1'b0, 3'b000, 3'b000, 3'b000, 5);
    add(1'b0, 3'b000, 3'b111, 3'b111, 1);
    add(1'b0, 3'b000, 3'b111, 3'b000, 2);
    add(1'b0, 3'b111, 3'b111, 3'b000, 5);
    add(1'b0, 3'b111, 3'b000, 3'b111, 1);
    add(1'b0, 3'b111, 3'b000, 3'b000, 2);

    foreach (vecs[i]) apply(vecs[i]);

`ifdef BUTTON_DEBOUNCE_BOUNCE_CNT_EN
    check_bounce({8'd1, 8'd2, 8'd0}, "after_table");
`endif

    // Reset while channel 2 is counting (cnt=2), pin held through reset.
    step(1'b0, 3'b011, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 4);
    step(1'b1, 3'b011, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 2);
`ifdef BUTTON_DEBOUNCE_BOUNCE_CNT_EN
    check_bounce({8'd0, 8'd0, 8'd0}, "after_reset");
`endif
    step(1'b0, 3'b011, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 5);
    step(1'b0, 3'b011, 3'b100, 3'b100, 3'b111, 3'b000, 3'b000, 1);
    step(1'b0, 3'b011, 3'b100, 3'b000, 3'b111, 3'b000, 3'b000, 1);
    step(1'b0, 3'b111, 3'b100, 3'b000, 3'b111, 3'b000, 3'b000, 5);
    step(1'b0, 3'b111, 3'b000, 3'b100, 3'b111, 3'b000, 3'b000, 1);
    step(1'b0, 3'b111, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 1);

    // Single-sample acceptance on dut_b: 2-cycle latency, one-sample pulse passes.
    step(1'b0, 3'b111, 3'b000, 3'b000, 3'b110, 3'b000, 3'b000, 2);
    step(1'b0, 3'b111, 3'b000, 3'b000, 3'b110, 3'b001, 3'b001, 1);
    step(1'b0, 3'b111, 3'b000, 3'b000, 3'b110, 3'b001, 3'b000, 1);
    step(1'b0, 3'b111, 3'b000, 3'b000, 3'b111, 3'b001, 3'b000, 2);
    step(1'b0, 3'b111, 3'b000, 3'b000, 3'b111, 3'b000, 3'b001, 1);
    step(1'b0, 3'b111, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 1);
    step(1'b0, 3'b111, 3'b000, 3'b000, 3'b110, 3'b000, 3'b000, 1);
    step(1'b0, 3'b111, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 1);
    step(1'b0, 3'b111, 3'b000, 3'b000, 3'b111, 3'b001, 3'b001, 1);
    step(1'b0, 3'b111, 3'b000, 3'b000, 3'b111, 3'b000, 3'b001, 1);
    step(1'b0, 3'b111, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
Multi-channel input conditioner that sits directly upstream of the ButtonShaper stage. It takes raw, asynchronous, bouncing push-button levels from board pins and synchronizes each one into clk. It normalizes polarity and emits a glitch-free level per button once the input has been stable long enough. Each btn_clean bit feeds one ButtonShaper instance, which converts the level into a one-cycle press pulse.

Parameters:
NUM_BTNS, 3, number of independent button channels
STABLE_CYCLES, 50000, consecutive identical samples required to accept a new level (1 ms at 50 MHz); legal range 1..2^20
ACTIVE_LOW, 1, 1 = board pin reads 0 when pressed; 0 = pin reads 1 when pressed
CNT_W, $clog2(STABLE_CYCLES+1), counter width; derived, not overridden

Ports:
clk  input  1  system clock; single clock domain
rst  input  1  synchronous, active-high reset
btn_raw  input  NUM_BTNS  raw pin levels, asynchronous to clk
btn_clean  output  NUM_BTNS  debounced level, 1 = pressed, regardless of ACTIVE_LOW
btn_changed  output  NUM_BTNS  one-cycle pulse on the cycle a btn_clean bit toggles

Behaviour:
- Per channel: 2-FF synchronizer (sync1, sync2). Sample s = sync2 XOR ACTIVE_LOW, so s = 1 means pressed.
- Reset, synchronous on rst=1:
  - sync1 and sync2 load the released pin level (ACTIVE_LOW ? 1 : 0).
  - Counter is cleared.
  - FSM goes to REL_STABLE.
  - btn_clean = 0 and btn_changed = 0 for all channels.
- Per-channel FSM, 4 states:
  - REL_STABLE: if s=1, go to PRESS_CNT with cnt=1. If STABLE_CYCLES==1, go directly to PRS_STABLE.
  - PRESS_CNT:
    - If s=0, return to REL_STABLE and clear cnt (bounce rejected; no output change).
    - If s=1 and cnt==STABLE_CYCLES-1, go to PRS_STABLE, set btn_clean=1, pulse btn_changed.
    - Otherwise cnt++.
  - PRS_STABLE: mirror of REL_STABLE, with s=0 leading to REL_CNT.
  - REL_CNT: mirror of PRESS_CNT. Acceptance clears btn_clean and pulses btn_changed.
- Latency: if a pin is first sampled at its new level on edge k and then stays stable, btn_clean updates after edge k+1+STABLE_CYCLES.
- Bounce rule: any reversal before acceptance restarts the count from zero. A pulse train shorter than STABLE_CYCLES never reaches the output.
- btn_changed is registered, high for exactly one cycle, and coincident with the btn_clean update.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous btn_changed bits.
- Counter never exceeds STABLE_CYCLES-1 and is idle (held at 0) in the stable states. No wrap-around is possible.
- Reset mid-count: the count is discarded and the channel returns to REL_STABLE with btn_clean=0. If the button is held through reset, it is re-accepted after the full latency following rst deassertion.
- No combinational path from btn_raw to any output.

Optional Feature:
BUTTON_DEBOUNCE_BOUNCE_CNT_EN
- Defined:
  - Adds output bounce_cnt [NUM_BTNS*8-1:0], one 8-bit counter per channel.
  - A counter increments on each rejected transition (a CNT state returning to its stable state).
  - It saturates at 255 and clears on rst.
  - Used for board diagnostics on LEDs/7-seg.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package: FSM state enum (REL_STABLE, PRESS_CNT, PRS_STABLE, REL_CNT), the released-level constant function, and the default STABLE_CYCLES for 50 MHz.
- One natural sub-module, debounce_channel: synchronizer, FSM and counter for a single bit. The top level generates NUM_BTNS instances.

Test Plan (STABLE_CYCLES=4, ACTIVE_LOW=1, NUM_BTNS=3, 20 ns clk):
1. Hold rst=1 for 3 cycles with btn_raw=3'b111 -> btn_clean=000 and btn_changed=000 during reset and after release; no spurious pulse.
2. btn_raw[0] driven 1->0 and held -> btn_clean[0] rises exactly 6 edges later (sampled at edge k, visible after edge k+5); btn_changed[0] high for that one cycle only.
3. btn_raw[1] toggles 0,1,0,1 every 2 cycles, then stays 0 -> no output during bouncing; btn_clean[1]=1 exactly 6 edges after the final stable sample. With BUTTON_DEBOUNCE_BOUNCE_CNT_EN defined, bounce_cnt[15:8] equals the number of rejected runs.
4. All three pins are pressed on the same edge, then released together -> btn_changed=111 on the same cycle for the press, and again for the release.
5. Assert rst while channel 2 is in PRESS_CNT with cnt=2 -> btn_clean[2] stays 0. After rst drops with the pin still pressed, btn_clean[2] rises after the full 6-edge latency.
6. Rerun scenario 2 with STABLE_CYCLES=1 -> btn_clean rises 3 edges after the first sample; no counting state is entered.
